// File: rtl/uart_sample_tx.sv
// rtl/uart_sample_tx.sv - packetised UART transmitter: header byte then N multi-byte samples
// Optional feature macro: UART_SAMPLE_TX_PARITY_EN (even parity bit after data bit 7 of every byte)

module uart_sample_tx #(
   parameter int         BIT_WIDTH = 24,
   parameter int         N         = 8,
   parameter int         CLK_FREQ  = 50000000,
   parameter int         BAUD      = 115200,
   parameter logic [7:0] HEADER    = 8'hA5
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 start,
   input  logic [BIT_WIDTH-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic                 tx_o,
   output logic                 busy,
   output logic                 done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int BYTES        = (BIT_WIDTH + 7) / 8;
   localparam int SW           = BYTES * 8;
   localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CW           = $clog2(N + 1);
   localparam int YW           = (BYTES > 1) ? $clog2(BYTES) : 1;
`ifdef UART_SAMPLE_TX_PARITY_EN
   localparam int FB           = 11;
`else
   localparam int FB           = 10;
`endif

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_sample_tx: CLK_FREQ/BAUD must be at least 2");
   end

   typedef enum logic [2:0] {IDLE, HDR, LOAD, SEND, DONE} state_e;

   state_e          state_q, state_d;
   logic            tx_q, tx_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [3:0]      bit_q, bit_d;
   logic [YW-1:0]   byte_q, byte_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [FB-1:0]   frame_q, frame_d;
   logic [SW-1:0]   samp_q, samp_d;

   logic            bit_end, pre_end, last_bit, last_byte;
   logic [CW-1:0]   cnt_inc;
   logic [SW-1:0]   samp_in;

   // Line image of one byte, bit 0 (start) goes out first
   function automatic logic [FB-1:0] make_frame(input logic [7:0] b);
`ifdef UART_SAMPLE_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b1, b, 1'b0};
`endif
   endfunction

   // Next-state logic; the last stop-bit cycle before a sample fetch is spent in LOAD so bytes stay back-to-back
   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      cnt_d     = cnt_q;
      frame_d   = frame_q;
      samp_d    = samp_q;
      samp_in   = SW'(s_data);
      bit_end   = (baud_q == BW'(CLKS_PER_BIT - 1));
      pre_end   = (baud_q == BW'(CLKS_PER_BIT - 2));
      last_bit  = (bit_q == 4'(FB - 1));
      last_byte = (byte_q == YW'(BYTES - 1));
      cnt_inc   = cnt_q + 1'b1;

      if (state_q == HDR || state_q == SEND) begin
         baud_d = baud_q + 1'b1;
         if (bit_end && !last_bit) begin
            baud_d = '0;
            bit_d  = bit_q + 4'd1;
            tx_d   = frame_q[bit_q + 4'd1];
         end
      end

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (start) begin
               state_d = HDR;
               frame_d = make_frame(HEADER);
               tx_d    = 1'b0;
               baud_d  = '0;
               bit_d   = '0;
               cnt_d   = '0;
            end
         end
         HDR: begin
            if (last_bit && pre_end) begin
               state_d = LOAD;
               baud_d  = '0;
               bit_d   = '0;
            end
         end
         LOAD: begin
            if (s_valid) begin
               state_d = SEND;
               frame_d = make_frame(samp_in[7:0]);
               samp_d  = samp_in >> 8;
               tx_d    = 1'b0;
               byte_d  = '0;
               baud_d  = '0;
               bit_d   = '0;
            end
         end
         SEND: begin
            if (last_bit) begin
               if (!last_byte) begin
                  if (bit_end) begin
                     frame_d = make_frame(samp_q[7:0]);
                     samp_d  = samp_q >> 8;
                     tx_d    = 1'b0;
                     byte_d  = byte_q + 1'b1;
                     baud_d  = '0;
                     bit_d   = '0;
                  end
               end else if (cnt_inc != CW'(N)) begin
                  if (pre_end) begin
                     state_d = LOAD;
                     cnt_d   = cnt_inc;
                     baud_d  = '0;
                     bit_d   = '0;
                  end
               end else if (bit_end) begin
                  state_d = DONE;
                  cnt_d   = cnt_inc;
                  baud_d  = '0;
                  bit_d   = '0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            cnt_d   = '0;
            byte_d  = '0;
            baud_d  = '0;
            bit_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any partial byte
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         tx_q    <= 1'b1;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         cnt_q   <= '0;
         frame_q <= '1;
         samp_q  <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         samp_q  <= samp_d;
      end
   end

   assign tx_o    = tx_q;
   assign s_ready = (state_q == LOAD);
   assign busy    = (state_q == HDR) || (state_q == LOAD) || (state_q == SEND);
   assign done    = (state_q == DONE);

endmodule
